// File: rtl/id_ex_bubble_stage.sv
// ID/EX pipeline register with load-use stall control, branch flush, sticky halt,
// saturating bubble statistics and a consecutive-stall watchdog.
module id_ex_bubble_stage #(
    parameter int PAYLOAD_W = 64,
    parameter int CNT_W     = 32,
    parameter int MAX_STALL = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 bubble,
    input  logic                 flush,
    input  logic                 halt,
    input  logic                 id_valid,
    input  logic                 id_reg_w_en,
    input  logic [4:0]           id_reg_req_w,
    input  logic                 id_mem_read_en,
    input  logic [PAYLOAD_W-1:0] id_payload,
    output logic                 pc_en,
    output logic                 ifid_en,
    output logic                 ifid_clr,
    output logic                 ex_valid,
    output logic                 ex_reg_w_en,
    output logic [4:0]           ex_reg_req_w,
    output logic                 ex_mem_read_en,
    output logic [PAYLOAD_W-1:0] ex_payload,
    output logic [CNT_W-1:0]     bubble_count,
    output logic                 halted,
    output logic                 stall_err
);

    localparam int SR_W = $clog2(MAX_STALL + 1);
    localparam logic [SR_W-1:0] STALL_MAX  = SR_W'(MAX_STALL);
    localparam logic [SR_W-1:0] STALL_LAST = SR_W'(MAX_STALL - 1);

    logic                 ex_valid_q, ex_valid_d;
    logic                 ex_reg_w_en_q, ex_reg_w_en_d;
    logic [4:0]           ex_reg_req_w_q, ex_reg_req_w_d;
    logic                 ex_mem_read_en_q, ex_mem_read_en_d;
    logic [PAYLOAD_W-1:0] ex_payload_q, ex_payload_d;
    logic [CNT_W-1:0]     bubble_count_q, bubble_count_d;
    logic                 halted_q, halted_d;
    logic                 stall_err_q, stall_err_d;
    logic [SR_W-1:0]      stall_run_q, stall_run_d;

    logic bubble_req;
    logic halt_req;
    logic load_id;

    // A flush squashes the ID instruction, so it masks both bubble and halt requests.
    assign bubble_req = bubble & ~halted_q & ~flush;
    assign halt_req   = halt & id_valid & ~flush & ~bubble;

    always_comb begin
        pc_en          = 1'b1;
        ifid_en        = 1'b1;
        ifid_clr       = 1'b0;
        load_id        = 1'b0;
        halted_d       = halted_q;
        bubble_count_d = bubble_count_q;
        stall_run_d    = '0;
        stall_err_d    = stall_err_q;

        if (halted_q) begin
            pc_en   = 1'b0;
            ifid_en = 1'b0;
        end else if (flush) begin
            ifid_clr = 1'b1;
        end else if (bubble_req) begin
            pc_en   = 1'b0;
            ifid_en = 1'b0;
            if (~&bubble_count_q) begin
                bubble_count_d = bubble_count_q + 1'b1;
            end
            if (stall_run_q != STALL_MAX) begin
                stall_run_d = stall_run_q + 1'b1;
            end else begin
                stall_run_d = stall_run_q;
            end
            if (stall_run_q >= STALL_LAST) begin
                stall_err_d = 1'b1;
            end
        end else begin
            // The halting instruction itself still advances into EX.
            load_id = id_valid;
            if (halt_req) begin
                halted_d = 1'b1;
            end
        end

        ex_valid_d       = load_id;
        ex_reg_w_en_d    = load_id ? id_reg_w_en    : 1'b0;
        ex_reg_req_w_d   = load_id ? id_reg_req_w   : 5'd0;
        ex_mem_read_en_d = load_id ? id_mem_read_en : 1'b0;
        ex_payload_d     = load_id ? id_payload     : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q       <= 1'b0;
            ex_reg_w_en_q    <= 1'b0;
            ex_reg_req_w_q   <= 5'd0;
            ex_mem_read_en_q <= 1'b0;
            ex_payload_q     <= '0;
            bubble_count_q   <= '0;
            halted_q         <= 1'b0;
            stall_err_q      <= 1'b0;
            stall_run_q      <= '0;
        end else begin
            ex_valid_q       <= ex_valid_d;
            ex_reg_w_en_q    <= ex_reg_w_en_d;
            ex_reg_req_w_q   <= ex_reg_req_w_d;
            ex_mem_read_en_q <= ex_mem_read_en_d;
            ex_payload_q     <= ex_payload_d;
            bubble_count_q   <= bubble_count_d;
            halted_q         <= halted_d;
            stall_err_q      <= stall_err_d;
            stall_run_q      <= stall_run_d;
        end
    end

    assign ex_valid       = ex_valid_q;
    assign ex_reg_w_en    = ex_reg_w_en_q;
    assign ex_reg_req_w   = ex_reg_req_w_q;
    assign ex_mem_read_en = ex_mem_read_en_q;
    assign ex_payload     = ex_payload_q;
    assign bubble_count   = bubble_count_q;
    assign halted         = halted_q;
    assign stall_err      = stall_err_q;

endmodule

// File: tb/tb_id_ex_bubble_stage.sv
// Directed bench for id_ex_bubble_stage: main instance with default widths plus a
// CNT_W=4 instance used only to observe bubble counter saturation.
module tb_id_ex_bubble_stage;

    localparam int PW = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          bubble, flush, halt, id_valid, id_reg_w_en, id_mem_read_en;
    logic [4:0]    id_reg_req_w;
    logic [PW-1:0] id_payload;
    logic          pc_en, ifid_en, ifid_clr, ex_valid, ex_reg_w_en, ex_mem_read_en;
    logic [4:0]    ex_reg_req_w;
    logic [PW-1:0] ex_payload;
    logic [31:0]   bubble_count;
    logic          halted, stall_err;

    logic          rst2_n, bubble2;
    logic          pc_en2, ifid_en2, ifid_clr2, ex_valid2, ex_reg_w_en2, ex_mem_read_en2;
    logic [4:0]    ex_reg_req_w2;
    logic [PW-1:0] ex_payload2;
    logic [3:0]    bubble_count2;
    logic          halted2, stall_err2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    id_ex_bubble_stage #(.PAYLOAD_W(PW), .CNT_W(32), .MAX_STALL(4)) dut (
        .clk(clk), .rst_n(rst_n), .bubble(bubble), .flush(flush), .halt(halt),
        .id_valid(id_valid), .id_reg_w_en(id_reg_w_en), .id_reg_req_w(id_reg_req_w),
        .id_mem_read_en(id_mem_read_en), .id_payload(id_payload),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_clr(ifid_clr), .ex_valid(ex_valid),
        .ex_reg_w_en(ex_reg_w_en), .ex_reg_req_w(ex_reg_req_w),
        .ex_mem_read_en(ex_mem_read_en), .ex_payload(ex_payload),
        .bubble_count(bubble_count), .halted(halted), .stall_err(stall_err)
    );

    id_ex_bubble_stage #(.PAYLOAD_W(PW), .CNT_W(4), .MAX_STALL(4)) dut_sat (
        .clk(clk), .rst_n(rst2_n), .bubble(bubble2), .flush(1'b0), .halt(1'b0),
        .id_valid(1'b1), .id_reg_w_en(1'b1), .id_reg_req_w(5'd3),
        .id_mem_read_en(1'b0), .id_payload({PW{1'b1}}),
        .pc_en(pc_en2), .ifid_en(ifid_en2), .ifid_clr(ifid_clr2), .ex_valid(ex_valid2),
        .ex_reg_w_en(ex_reg_w_en2), .ex_reg_req_w(ex_reg_req_w2),
        .ex_mem_read_en(ex_mem_read_en2), .ex_payload(ex_payload2),
        .bubble_count(bubble_count2), .halted(halted2), .stall_err(stall_err2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic w, input logic [4:0] r,
                          input logic ld, input logic [PW-1:0] p);
        id_valid       = v;
        id_reg_w_en    = w;
        id_reg_req_w   = r;
        id_mem_read_en = ld;
        id_payload     = p;
    endtask

    initial begin
        rst_n = 1'b0; rst2_n = 1'b0; bubble2 = 1'b0;
        bubble = 1'b0; flush = 1'b0; halt = 1'b0;
        set_id(1'b0, 1'b0, 5'd0, 1'b0, '0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ex_valid", 64'(ex_valid), 64'd0);
        chk("rst_bubble_count", 64'(bubble_count), 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);
        chk("rst_stall_err", 64'(stall_err), 64'd0);
        rst_n = 1'b1; rst2_n = 1'b1;

        // Plain advance
        set_id(1'b1, 1'b1, 5'd7, 1'b0, 64'hDEAD);
        #1;
        chk("norm_pc_en", 64'(pc_en), 64'd1);
        chk("norm_ifid_clr", 64'(ifid_clr), 64'd0);
        step();
        chk("norm_ex_reg", 64'(ex_reg_req_w), 64'd7);
        chk("norm_ex_payload", ex_payload, 64'hDEAD);
        chk("norm_ex_valid", 64'(ex_valid), 64'd1);

        // One bubble so the count is nonzero before the async reset
        bubble = 1'b1;
        #1;
        chk("bub_pc_en", 64'(pc_en), 64'd0);
        step();
        bubble = 1'b0;
        chk("bub_count1", 64'(bubble_count), 64'd1);
        step();
        chk("pre_rst_ex_reg", 64'(ex_reg_req_w), 64'd7);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_ex_reg", 64'(ex_reg_req_w), 64'd0);
        chk("async_rst_ex_valid", 64'(ex_valid), 64'd0);
        chk("async_rst_count", 64'(bubble_count), 64'd0);
        #1 rst_n = 1'b1;
        step();

        // Load-use: load writes $t0 (8), dependent instruction behind it
        set_id(1'b1, 1'b1, 5'd8, 1'b1, 64'h10);
        step();
        chk("lu_ex_load", 64'(ex_mem_read_en), 64'd1);
        chk("lu_ex_reg8", 64'(ex_reg_req_w), 64'd8);
        set_id(1'b1, 1'b1, 5'd9, 1'b0, 64'h1234);
        bubble = 1'b1;
        #1;
        chk("lu_pc_en", 64'(pc_en), 64'd0);
        chk("lu_ifid_en", 64'(ifid_en), 64'd0);
        step();
        chk("lu_nop_valid", 64'(ex_valid), 64'd0);
        chk("lu_nop_load", 64'(ex_mem_read_en), 64'd0);
        chk("lu_count", 64'(bubble_count), 64'd1);
        bubble = 1'b0;
        step();
        chk("lu_dep_reg", 64'(ex_reg_req_w), 64'd9);
        chk("lu_dep_payload", ex_payload, 64'h1234);
        chk("lu_dep_valid", 64'(ex_valid), 64'd1);

        // Invalid ID instruction loads NOP fields
        set_id(1'b0, 1'b1, 5'd12, 1'b1, 64'hFFFF);
        step();
        chk("inv_reg_w_en", 64'(ex_reg_w_en), 64'd0);
        chk("inv_reg", 64'(ex_reg_req_w), 64'd0);
        chk("inv_payload", ex_payload, 64'd0);

        // Flush beats a simultaneous bubble
        set_id(1'b1, 1'b1, 5'd5, 1'b0, 64'h55);
        flush = 1'b1; bubble = 1'b1;
        #1;
        chk("fl_pc_en", 64'(pc_en), 64'd1);
        chk("fl_ifid_en", 64'(ifid_en), 64'd1);
        chk("fl_ifid_clr", 64'(ifid_clr), 64'd1);
        step();
        chk("fl_ex_valid", 64'(ex_valid), 64'd0);
        chk("fl_count", 64'(bubble_count), 64'd1);
        flush = 1'b0;

        // Watchdog: 3 consecutive bubbles are tolerated
        repeat (3) step();
        chk("wd3_stall_err", 64'(stall_err), 64'd0);
        chk("wd3_count", 64'(bubble_count), 64'd4);
        bubble = 1'b0;
        step();
        bubble = 1'b1;
        repeat (3) step();
        chk("wd4_before", 64'(stall_err), 64'd0);
        step();
        chk("wd4_stall_err", 64'(stall_err), 64'd1);
        chk("wd4_count", 64'(bubble_count), 64'd8);
        bubble = 1'b0;
        step();
        chk("wd_sticky", 64'(stall_err), 64'd1);
        chk("wd_resume_valid", 64'(ex_valid), 64'd1);

        // Halt: halting instruction enters EX, then everything freezes
        set_id(1'b1, 1'b1, 5'd2, 1'b0, 64'h2);
        halt = 1'b1;
        step();
        chk("halt_ex_reg", 64'(ex_reg_req_w), 64'd2);
        chk("halt_ex_valid", 64'(ex_valid), 64'd1);
        chk("halt_flag", 64'(halted), 64'd1);
        halt = 1'b0; bubble = 1'b1;
        set_id(1'b1, 1'b1, 5'd4, 1'b0, 64'h4);
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("halted_pc_en", 64'(pc_en), 64'd0);
            step();
            chk("halted_ex_valid", 64'(ex_valid), 64'd0);
        end
        chk("halted_count", 64'(bubble_count), 64'd8);
        chk("halted_sticky", 64'(halted), 64'd1);
        bubble = 1'b0;

        // Saturation on the 4-bit counter instance: 20 separated bubbles
        for (int i = 0; i < 20; i++) begin
            bubble2 = 1'b1;
            step();
            bubble2 = 1'b0;
            step();
            if (i == 13) chk("sat_count14", 64'(bubble_count2), 64'hE);
        end
        chk("sat_count20", 64'(bubble_count2), 64'hF);
        chk("sat_no_stall_err", 64'(stall_err2), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
